// File: rtl/bsg_asic_clk_ctrl.sv
// Bring-up and gating sequencer for the ASIC io/core clock buffers, clocked by the board oscillator.
// Optional lock-loss event counter: define BSG_ASIC_CLK_CTRL_LOSS_CNT_EN to add lock_loss_cnt_o.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | all off, counting consecutive synchronized-lock cycles
// IO_EN     | io clock buffer enabled, io domain still in reset
// IO_REL    | io domain reset released
// CORE_EN   | core clock buffer enabled, core domain still in reset
// CORE_REL  | core domain reset released
// RUN       | fully up, ready_o high, accepting gate requests
// GATING    | core clock stopped, settling before acknowledge
// GATED     | core clock stopped and acknowledged, waiting for request drop
// UNGATING  | core clock restarted, settling before dropping acknowledge

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_asic_clk_ctrl #(
    parameter int lock_stable_p = 1024,
    parameter int gap_p         = 16
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       locked_i,
    input  logic       core_gate_req_i,
    output logic       io_clk_en_o,
    output logic       core_clk_en_o,
    output logic       io_reset_o,
    output logic       core_reset_o,
    output logic       core_gate_ack_o,
    output logic       ready_o
`ifdef BSG_ASIC_CLK_CTRL_LOSS_CNT_EN
   ,output logic [7:0] lock_loss_cnt_o
`endif
);

    localparam int max_cnt_lp   = (lock_stable_p > gap_p) ? lock_stable_p : gap_p;
    localparam int cnt_width_lp = `BSG_SAFE_CLOG2(max_cnt_lp + 1);

    localparam logic [cnt_width_lp-1:0] lock_last_lp = cnt_width_lp'(lock_stable_p - 1);
    localparam logic [cnt_width_lp-1:0] gap_last_lp  = cnt_width_lp'(gap_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp   = cnt_width_lp'(1);

    typedef enum logic [3:0] {
        WAIT_LOCK = 4'd0,
        IO_EN     = 4'd1,
        IO_REL    = 4'd2,
        CORE_EN   = 4'd3,
        CORE_REL  = 4'd4,
        RUN       = 4'd5,
        GATING    = 4'd6,
        GATED     = 4'd7,
        UNGATING  = 4'd8
    } state_e;

    state_e                  state_q, state_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                    lock_meta_q, lock_s_q;
    logic                    lock_lost;
    logic                    gap_done;

    logic io_en_q, io_en_d;
    logic core_en_q, core_en_d;
    logic io_rst_q, io_rst_d;
    logic core_rst_q, core_rst_d;
    logic ack_q, ack_d;
    logic ready_q, ready_d;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= locked_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gap_done  = (cnt_q == gap_last_lp);
    assign lock_lost = !lock_s_q && (state_q != WAIT_LOCK);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (!lock_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == lock_last_lp) begin
                    state_d = IO_EN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_one_lp;
                end
            end
            IO_EN, IO_REL, CORE_EN, CORE_REL, GATING, UNGATING: begin
                if (gap_done) begin
                    cnt_d = '0;
                    unique case (state_q)
                        IO_EN:    state_d = IO_REL;
                        IO_REL:   state_d = CORE_EN;
                        CORE_EN:  state_d = CORE_REL;
                        CORE_REL: state_d = RUN;
                        GATING:   state_d = GATED;
                        default:  state_d = RUN;
                    endcase
                end else begin
                    cnt_d = cnt_q + cnt_one_lp;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (core_gate_req_i) state_d = GATING;
            end
            GATED: begin
                cnt_d = '0;
                if (!core_gate_req_i) state_d = UNGATING;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        // Losing lock overrides every other transition.
        if (lock_lost) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end
    end

    // Outputs are decoded from the next state so each one changes on the first cycle of its state.
    always_comb begin
        io_en_d    = 1'b0;
        core_en_d  = 1'b0;
        io_rst_d   = 1'b1;
        core_rst_d = 1'b1;
        ack_d      = 1'b0;
        ready_d    = 1'b0;
        unique case (state_d)
            IO_EN: begin
                io_en_d = 1'b1;
            end
            IO_REL: begin
                io_en_d  = 1'b1;
                io_rst_d = 1'b0;
            end
            CORE_EN: begin
                io_en_d   = 1'b1;
                io_rst_d  = 1'b0;
                core_en_d = 1'b1;
            end
            CORE_REL: begin
                io_en_d    = 1'b1;
                io_rst_d   = 1'b0;
                core_en_d  = 1'b1;
                core_rst_d = 1'b0;
            end
            RUN: begin
                io_en_d    = 1'b1;
                io_rst_d   = 1'b0;
                core_en_d  = 1'b1;
                core_rst_d = 1'b0;
                ready_d    = 1'b1;
            end
            GATING: begin
                io_en_d    = 1'b1;
                io_rst_d   = 1'b0;
                core_rst_d = 1'b0;
            end
            GATED: begin
                io_en_d    = 1'b1;
                io_rst_d   = 1'b0;
                core_rst_d = 1'b0;
                ack_d      = 1'b1;
            end
            UNGATING: begin
                io_en_d    = 1'b1;
                io_rst_d   = 1'b0;
                core_en_d  = 1'b1;
                core_rst_d = 1'b0;
                ack_d      = 1'b1;
            end
            default: begin
                io_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            io_en_q    <= 1'b0;
            core_en_q  <= 1'b0;
            io_rst_q   <= 1'b1;
            core_rst_q <= 1'b1;
            ack_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            io_en_q    <= io_en_d;
            core_en_q  <= core_en_d;
            io_rst_q   <= io_rst_d;
            core_rst_q <= core_rst_d;
            ack_q      <= ack_d;
            ready_q    <= ready_d;
        end
    end

    assign io_clk_en_o     = io_en_q;
    assign core_clk_en_o   = core_en_q;
    assign io_reset_o      = io_rst_q;
    assign core_reset_o    = core_rst_q;
    assign core_gate_ack_o = ack_q;
    assign ready_o         = ready_q;

`ifdef BSG_ASIC_CLK_CTRL_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_lost && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) loss_cnt_q <= 8'd0;
        else            loss_cnt_q <= loss_cnt_d;
    end

    assign lock_loss_cnt_o = loss_cnt_q;
`endif

endmodule

// File: tb/tb_bsg_asic_clk_ctrl.sv
// Scoreboard bench for bsg_asic_clk_ctrl: stimulus queues the expected output transitions
// (cycle and value), a negedge monitor pops and compares on every observed output change.
module tb_bsg_asic_clk_ctrl;

    localparam int lock_stable_p = 8;
    localparam int gap_p         = 4;

    // {io_clk_en, core_clk_en, io_reset, core_reset, ack, ready}
    localparam logic [5:0] V_RST      = 6'b001100;
    localparam logic [5:0] V_IO_EN    = 6'b101100;
    localparam logic [5:0] V_IO_REL   = 6'b100100;
    localparam logic [5:0] V_CORE_EN  = 6'b110100;
    localparam logic [5:0] V_CORE_REL = 6'b110000;
    localparam logic [5:0] V_RUN      = 6'b110001;
    localparam logic [5:0] V_GATING   = 6'b100000;
    localparam logic [5:0] V_GATED    = 6'b100010;
    localparam logic [5:0] V_UNGATING = 6'b110010;

    logic clk_i           = 1'b0;
    logic reset_n_i       = 1'b0;
    logic locked_i        = 1'b0;
    logic core_gate_req_i = 1'b0;
    logic io_clk_en_o, core_clk_en_o, io_reset_o, core_reset_o, core_gate_ack_o, ready_o;
`ifdef BSG_ASIC_CLK_CTRL_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt_o;
`endif

    bsg_asic_clk_ctrl #(
        .lock_stable_p(lock_stable_p),
        .gap_p        (gap_p)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .locked_i       (locked_i),
        .core_gate_req_i(core_gate_req_i),
        .io_clk_en_o    (io_clk_en_o),
        .core_clk_en_o  (core_clk_en_o),
        .io_reset_o     (io_reset_o),
        .core_reset_o   (core_reset_o),
        .core_gate_ack_o(core_gate_ack_o),
        .ready_o        (ready_o)
`ifdef BSG_ASIC_CLK_CTRL_LOSS_CNT_EN
       ,.lock_loss_cnt_o(lock_loss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    logic [5:0] out_vec;
    assign out_vec = {io_clk_en_o, core_clk_en_o, io_reset_o, core_reset_o, core_gate_ack_o, ready_o};

    int         exp_cyc_q[$];
    logic [5:0] exp_vec_q[$];
    logic [5:0] prev_vec = V_RST;
    int         mon_cyc;
    logic [5:0] mon_vec;

    task automatic push(input int c, input logic [5:0] v);
        exp_cyc_q.push_back(c);
        exp_vec_q.push_back(v);
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    always @(negedge clk_i) begin
        if (out_vec !== prev_vec) begin
            checks++;
            if (exp_vec_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%b prev=%b", cyc, out_vec, prev_vec);
            end else begin
                mon_cyc = exp_cyc_q.pop_front();
                mon_vec = exp_vec_q.pop_front();
                if (cyc != mon_cyc || out_vec !== mon_vec) begin
                    errors++;
                    $display("FAIL out_event got cyc=%0d vec=%b expected cyc=%0d vec=%b",
                             cyc, out_vec, mon_cyc, mon_vec);
                end
            end
            prev_vec = out_vec;
        end
    end

    task automatic bring_up_expect(input int k);
        push(k + 10, V_IO_EN);
        push(k + 14, V_IO_REL);
        push(k + 18, V_CORE_EN);
        push(k + 22, V_CORE_REL);
        push(k + 26, V_RUN);
    endtask

    initial begin
        int k, m, n, p, q, r, s, t;
        @(posedge clk_i);
        #1;
        tick_to(4);
        checks++;
        if (out_vec !== V_RST) begin
            errors++;
            $display("FAIL reset_values got=%b expected=%b", out_vec, V_RST);
        end
        reset_n_i = 1'b1;
        tick_to(6);

        // Clean bring-up.
        k = cyc;
        bring_up_expect(k);
        locked_i = 1'b1;
        tick_to(k + 30);

        // Normal gate / ungate handshake.
        m = cyc;
        push(m + 1, V_GATING);
        push(m + 5, V_GATED);
        core_gate_req_i = 1'b1;
        tick_to(m + 8);
        n = cyc;
        push(n + 1, V_UNGATING);
        push(n + 5, V_RUN);
        core_gate_req_i = 1'b0;
        tick_to(n + 8);

        // Early drop during GATING and early reassert during UNGATING are deferred.
        p = cyc;
        push(p + 1,  V_GATING);
        push(p + 5,  V_GATED);
        push(p + 6,  V_UNGATING);
        push(p + 10, V_RUN);
        push(p + 11, V_GATING);
        push(p + 15, V_GATED);
        push(p + 16, V_UNGATING);
        push(p + 20, V_RUN);
        core_gate_req_i = 1'b1;
        tick_to(p + 2);
        core_gate_req_i = 1'b0;
        tick_to(p + 7);
        core_gate_req_i = 1'b1;
        tick_to(p + 12);
        core_gate_req_i = 1'b0;
        tick_to(p + 24);

        // Lock loss while GATED (request still held).
        q = cyc;
        push(q + 1,  V_GATING);
        push(q + 5,  V_GATED);
        push(q + 10, V_RST);
        core_gate_req_i = 1'b1;
        tick_to(q + 7);
        locked_i = 1'b0;
        tick_to(q + 11);
        core_gate_req_i = 1'b0;
        tick_to(q + 12);

        // Short lock glitch restarts the stability count, then lock loss during CORE_EN.
        r = cyc;
        push(r + 16, V_IO_EN);
        push(r + 20, V_IO_REL);
        push(r + 24, V_CORE_EN);
        push(r + 27, V_RST);
        locked_i = 1'b1;
        tick_to(r + 5);
        locked_i = 1'b0;
        tick_to(r + 6);
        locked_i = 1'b1;
        tick_to(r + 24);
        locked_i = 1'b0;
        tick_to(r + 30);

`ifdef BSG_ASIC_CLK_CTRL_LOSS_CNT_EN
        checks++;
        if (lock_loss_cnt_o !== 8'd2) begin
            errors++;
            $display("FAIL loss_cnt_two got=%0d expected=2", lock_loss_cnt_o);
        end
        for (int i = 0; i < 298; i++) begin
            k = cyc;
            push(k + 10, V_IO_EN);
            push(k + 13, V_RST);
            locked_i = 1'b1;
            tick_to(k + 10);
            locked_i = 1'b0;
            tick_to(k + 14);
        end
        checks++;
        if (lock_loss_cnt_o !== 8'hFF) begin
            errors++;
            $display("FAIL loss_cnt_sat got=%0d expected=255", lock_loss_cnt_o);
        end
`endif

        // Full re-sequence after loss.
        s = cyc;
        bring_up_expect(s);
        locked_i = 1'b1;
        tick_to(s + 30);

        // Asynchronous reset mid-RUN.
        t = cyc;
        push(t, V_RST);
        #1;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (out_vec !== V_RST) begin
            errors++;
            $display("FAIL async_reset got=%b expected=%b", out_vec, V_RST);
        end
        tick_to(t + 4);

        checks++;
        if (exp_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d expected=0", exp_cyc_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
